// File: rtl/cpu_mem_pkg.sv
// Shared types and default widths for the CPU data-memory path.
package cpu_mem_pkg;
    localparam int ADDR_W_DEF     = 16;
    localparam int DATA_W_DEF     = 16;
    localparam int MEM_DEPTH_DEF  = 16;
    localparam int RD_LATENCY_DEF = 1;
    localparam int REG_W_DEF      = 3;
    localparam int LAT_CNT_W      = 3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } mem_state_t;
endpackage

// File: rtl/data_mem_initiator.sv
// Single-outstanding load/store initiator between the execute stage and data memory.
// All memory-side outputs are registered so strobes are glitch-free and last exactly one cycle.
module data_mem_initiator
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MEM_DEPTH  = MEM_DEPTH_DEF,
    parameter int RD_LATENCY = RD_LATENCY_DEF,
    parameter int REG_W      = REG_W_DEF
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [REG_W-1:0]  req_rd,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [REG_W-1:0]  resp_rd,
    output logic              resp_fault,
    output logic              Memread,
    output logic              Memwrite,
    output logic              Memtoreg,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] Datawrite,
    input  logic [DATA_W-1:0] Readdata
);

    // One extra bit keeps the range compare unsigned even when MEM_DEPTH == 2**ADDR_W.
    localparam logic [ADDR_W:0]        DEPTH_LIM = (ADDR_W + 1)'(MEM_DEPTH);
    localparam logic [LAT_CNT_W-1:0]   LAT_INIT  = LAT_CNT_W'(RD_LATENCY);

    mem_state_t            state_reg, state_next;
    logic                  write_reg, write_next;
    logic [LAT_CNT_W-1:0]  cnt_reg, cnt_next;
    logic                  resp_valid_reg, resp_valid_next;
    logic [DATA_W-1:0]     resp_data_reg, resp_data_next;
    logic [REG_W-1:0]      resp_rd_reg, resp_rd_next;
    logic                  resp_fault_reg, resp_fault_next;
    logic                  memread_reg, memread_next;
    logic                  memwrite_reg, memwrite_next;
    logic                  memtoreg_reg, memtoreg_next;
    logic [ADDR_W-1:0]     addr_reg, addr_next;
    logic [DATA_W-1:0]     datawrite_reg, datawrite_next;
    logic                  addr_fault;

    assign addr_fault = ({1'b0, req_addr} >= DEPTH_LIM);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg      <= IDLE;
            write_reg      <= 1'b0;
            cnt_reg        <= '0;
            resp_valid_reg <= 1'b0;
            resp_data_reg  <= '0;
            resp_rd_reg    <= '0;
            resp_fault_reg <= 1'b0;
            memread_reg    <= 1'b0;
            memwrite_reg   <= 1'b0;
            memtoreg_reg   <= 1'b0;
            addr_reg       <= '0;
            datawrite_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            write_reg      <= write_next;
            cnt_reg        <= cnt_next;
            resp_valid_reg <= resp_valid_next;
            resp_data_reg  <= resp_data_next;
            resp_rd_reg    <= resp_rd_next;
            resp_fault_reg <= resp_fault_next;
            memread_reg    <= memread_next;
            memwrite_reg   <= memwrite_next;
            memtoreg_reg   <= memtoreg_next;
            addr_reg       <= addr_next;
            datawrite_reg  <= datawrite_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        write_next      = write_reg;
        cnt_next        = cnt_reg;
        resp_valid_next = resp_valid_reg;
        resp_data_next  = resp_data_reg;
        resp_rd_next    = resp_rd_reg;
        resp_fault_next = resp_fault_reg;
        memread_next    = 1'b0;
        memwrite_next   = 1'b0;
        memtoreg_next   = memtoreg_reg;
        addr_next       = addr_reg;
        datawrite_next  = datawrite_reg;

        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    write_next     = req_write;
                    resp_rd_next   = req_rd;
                    resp_data_next = '0;
                    if (addr_fault) begin
                        // Out-of-range requests never touch the memory port.
                        resp_fault_next = 1'b1;
                        resp_valid_next = 1'b1;
                        memtoreg_next   = 1'b0;
                        state_next      = RESP;
                    end else begin
                        resp_fault_next = 1'b0;
                        addr_next       = req_addr;
                        datawrite_next  = req_wdata;
                        memwrite_next   = req_write;
                        memread_next    = !req_write;
                        memtoreg_next   = !req_write;
                        state_next      = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (write_reg) begin
                    resp_valid_next = 1'b1;
                    state_next      = RESP;
                end else begin
                    cnt_next   = LAT_INIT;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg == LAT_CNT_W'(1)) begin
                    resp_data_next  = Readdata;
                    resp_valid_next = 1'b1;
                    memtoreg_next   = 1'b0;
                    state_next      = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_next = 1'b0;
                    state_next      = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign req_ready  = (state_reg == IDLE);
    assign resp_valid = resp_valid_reg;
    assign resp_data  = resp_data_reg;
    assign resp_rd    = resp_rd_reg;
    assign resp_fault = resp_fault_reg;
    assign Memread    = memread_reg;
    assign Memwrite   = memwrite_reg;
    assign Memtoreg   = memtoreg_reg;
    assign addr       = addr_reg;
    assign Datawrite  = datawrite_reg;

endmodule

// File: tb/tb_data_mem_initiator.sv
// Directed + scoreboard bench for data_mem_initiator at read latency 1 and 3.
module tb_data_mem_initiator;

    typedef struct {
        logic [2:0]  rd;
        logic [15:0] data;
        logic        fault;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid, req_ready, req_write, resp_valid, resp_ready, resp_fault;
    logic [15:0] req_addr, req_wdata, resp_data, mem_addr, data_write, read_data;
    logic [2:0]  req_rd, resp_rd;
    logic        mem_read, mem_write, mem_to_reg;

    logic        req_valid3, req_ready3, req_write3, resp_valid3, resp_ready3, resp_fault3;
    logic [15:0] req_addr3, req_wdata3, resp_data3, mem_addr3, data_write3, read_data3;
    logic [2:0]  req_rd3, resp_rd3;
    logic        mem_read3, mem_write3, mem_to_reg3;

    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    logic [15:0] ref_mem [16];

    data_mem_initiator u_dut (
        .Clk(clk), .Rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_rd(resp_rd), .resp_fault(resp_fault),
        .Memread(mem_read), .Memwrite(mem_write), .Memtoreg(mem_to_reg),
        .addr(mem_addr), .Datawrite(data_write), .Readdata(read_data)
    );

    data_mem_initiator #(.RD_LATENCY(3)) u_dut3 (
        .Clk(clk), .Rst_n(rst_n),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_write(req_write3),
        .req_addr(req_addr3), .req_wdata(req_wdata3), .req_rd(req_rd3),
        .resp_valid(resp_valid3), .resp_ready(resp_ready3), .resp_data(resp_data3),
        .resp_rd(resp_rd3), .resp_fault(resp_fault3),
        .Memread(mem_read3), .Memwrite(mem_write3), .Memtoreg(mem_to_reg3),
        .addr(mem_addr3), .Datawrite(data_write3), .Readdata(read_data3)
    );

    // Memory models: data is only valid exactly RD_LATENCY cycles after Memread, 0xDEAD otherwise.
    logic [15:0] mem1 [16];
    logic [15:0] pipe1;
    always @(posedge clk) begin
        if (mem_write) mem1[mem_addr[3:0]] <= data_write;
        pipe1 <= mem_read ? mem1[mem_addr[3:0]] : 16'hDEAD;
    end
    assign read_data = pipe1;

    logic [15:0] mem3 [16];
    logic [15:0] pipe3 [3];
    always @(posedge clk) begin
        if (mem_write3) mem3[mem_addr3[3:0]] <= data_write3;
        pipe3[0] <= mem_read3 ? mem3[mem_addr3[3:0]] : 16'hDEAD;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign read_data3 = pipe3[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic txn(input logic w, input logic [15:0] a, input logic [15:0] d,
                       input logic [2:0] rd, input int stall);
        exp_t e;
        int   k, nrd, nwr, exp_k;
        logic flt;
        flt     = (a >= 16'd16);
        e.rd    = rd;
        e.fault = flt;
        e.data  = (flt || w) ? 16'h0 : ref_mem[a[3:0]];
        if (w && !flt) ref_mem[a[3:0]] = d;
        sb.push_back(e);
        exp_k = flt ? 1 : (w ? 2 : 3);

        @(negedge clk);
        check("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_rd = rd;
        @(negedge clk);
        req_valid = 1'b0;
        nrd = 0; nwr = 0; k = 1;
        forever begin
            if (mem_read)  begin nrd++; check("rd_strobe_cycle", k, 1); end
            if (mem_write) begin nwr++; check("wr_strobe_cycle", k, 1); end
            if (resp_valid || k >= 20) break;
            @(negedge clk);
            k++;
        end
        check("resp_latency", k, exp_k);
        check("memread_count", nrd, (!w && !flt) ? 1 : 0);
        check("memwrite_count", nwr, (w && !flt) ? 1 : 0);

        for (int s = 0; s < stall; s++) begin
            check("stall_valid", resp_valid, 1'b1);
            check("stall_req_ready", req_ready, 1'b0);
            check("stall_data", resp_data, sb[0].data);
            check("stall_rd", resp_rd, sb[0].rd);
            @(negedge clk);
        end

        e = sb.pop_front();
        $display("txn w=%0d addr=%0h rd=%0d lat=%0d data=%0h fault=%0d", w, a, resp_rd, k, resp_data, resp_fault);
        check("resp_valid", resp_valid, 1'b1);
        check("resp_data", resp_data, e.data);
        check("resp_rd", resp_rd, e.rd);
        check("resp_fault", resp_fault, e.fault);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    initial begin
        int k, nrd;
        rst_n = 1'b0;
        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_rd = 0; resp_ready = 0;
        req_valid3 = 0; req_write3 = 0; req_addr3 = 0; req_wdata3 = 0; req_rd3 = 0; resp_ready3 = 0;
        for (int i = 0; i < 16; i++) begin
            mem1[i]    <= 16'h0100 + 16'(i);
            mem3[i]    <= (i == 0) ? 16'd20 : 16'h0300 + 16'(i);
            ref_mem[i] = 16'h0100 + 16'(i);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_strobes", {mem_read, mem_write, mem_to_reg, resp_fault}, 4'b0);
        check("rst_addr", mem_addr, 16'h0);
        check("rst_datawrite", data_write, 16'h0);
        check("rst_resp_data", resp_data, 16'h0);
        check("rst_resp_rd", resp_rd, 3'h0);

        // store then load back
        txn(1'b1, 16'd3, 16'h00AA, 3'd1, 0);
        txn(1'b0, 16'd3, 16'h0000, 3'd2, 0);

        // latency-3 instance: load preloaded word at address 0
        @(negedge clk);
        req_valid3 = 1'b1; req_addr3 = 16'd0; req_rd3 = 3'd6;
        @(negedge clk);
        req_valid3 = 1'b0;
        k = 1; nrd = 0;
        forever begin
            if (mem_read3) nrd++;
            if (resp_valid3 || k >= 20) break;
            @(negedge clk);
            k++;
        end
        $display("txn lat3 addr=0 rd=%0d lat=%0d data=%0d", resp_rd3, k, resp_data3);
        check("lat3_latency", k, 5);
        check("lat3_memread_count", nrd, 1);
        check("lat3_data", resp_data3, 16'd20);
        check("lat3_rd", resp_rd3, 3'd6);
        resp_ready3 = 1'b1;
        @(posedge clk);
        #1 resp_ready3 = 1'b0;

        // address boundary
        txn(1'b0, 16'd16, 16'h0000, 3'd3, 0);
        txn(1'b1, 16'hFFFF, 16'h1234, 3'd3, 0);
        txn(1'b0, 16'd15, 16'h0000, 3'd4, 0);

        // backpressure
        txn(1'b0, 16'd7, 16'h0000, 3'd5, 5);

        // reset during WAIT
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'd5; req_rd = 3'd6;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("pre_reset_memtoreg", mem_to_reg, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        $display("txn reset-in-wait rd=6 resp_valid=%0d memtoreg=%0d", resp_valid, mem_to_reg);
        check("mid_rst_resp_valid", resp_valid, 1'b0);
        check("mid_rst_memtoreg", mem_to_reg, 1'b0);
        check("mid_rst_addr", mem_addr, 16'h0);
        check("mid_rst_req_ready", req_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_no_resp", resp_valid, 1'b0);
        end
        txn(1'b0, 16'd3, 16'h0000, 3'd7, 0);

        // back-to-back random traffic
        for (int i = 0; i < 8; i++) begin
            logic        w;
            logic [15:0] a;
            w = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 7) == 0) ? 16'd16 : 16'($urandom_range(0, 15));
            txn(w, a, 16'($urandom), 3'(i), int'($urandom_range(0, 3)));
        end
        check("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_initiator.md
# data_mem_initiator

Load/store initiator for the 16-bit CPU's data memory port. Accepts one load or store request at a time from the execute stage over a valid/ready handshake and drives the data memory strobes (Memread, Memwrite, Memtoreg), address and write data. It waits a fixed read latency, captures Readdata and returns a response over a second valid/ready handshake. It sits between the execute stage and the data memory and is the only driver of the memory's control inputs.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MEM_DEPTH, 16, number of valid memory words; addresses >= MEM_DEPTH fault
- RD_LATENCY, 1, cycles from read strobe to valid Readdata (1..7)
- REG_W, 3, destination register tag width

- Clk  in  1  clock, rising edge
- Rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept (high only in IDLE)
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  store data
- req_rd  in  REG_W  destination tag, returned with response
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_data  out  DATA_W  load data; 0 for stores and faults
- resp_rd  out  REG_W  tag of the request
- resp_fault  out  1  address out of range; no memory access made
- Memread  out  1  memory read strobe
- Memwrite  out  1  memory write strobe
- Memtoreg  out  1  1 selects memory data onto Readdata
- addr  out  ADDR_W  memory address
- Datawrite  out  DATA_W  memory write data
- Readdata  in  DATA_W  memory read data

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid, latch write/addr/wdata/rd.
  - If addr >= MEM_DEPTH: set fault, resp_data=0, go to RESP.
  - Otherwise go to ISSUE.
- ISSUE: exactly one cycle. addr/Datawrite driven from the latch.
  - Store: Memwrite=1, then RESP.
  - Load: Memread=1, Memtoreg=1, load the latency counter with RD_LATENCY, then WAIT.
- WAIT: Memtoreg=1 and addr held, strobes low. Counter decrements each cycle. In the cycle it reads 1, capture Readdata into resp_data and go to RESP.
- RESP: resp_valid=1, outputs stable until resp_ready. On resp_ready, go to IDLE; a new request can be accepted the next cycle.
- Strobes are registered and never high outside ISSUE; Memread and Memwrite are never high together.
- req_ready is low outside IDLE. req_valid with req_ready low is ignored and must be held by the producer.

## Timing
- Reset values: state IDLE. All of req_ready=1, resp_valid, resp_fault, Memread, Memwrite and Memtoreg are 0. addr, Datawrite, resp_data and resp_rd are 0.
- Let T be the accept cycle.
  - Store: Memwrite high in T+1, resp_valid from T+2.
  - Load: Memread high in T+1, Readdata sampled at the end of T+1+RD_LATENCY, resp_valid from T+2+RD_LATENCY (T+3 at default).
  - Fault: resp_valid from T+1, no strobe ever asserted.
- Throughput: one request per 3 (store) or 3+RD_LATENCY (load) cycles, with resp_ready held high.
- resp_ready low stalls in RESP indefinitely with no output change.
- Reset asserted mid-transaction immediately drops strobes and resp_valid and discards the in-flight request. A write already strobed is not rolled back.
- Address boundary: MEM_DEPTH-1 is valid; MEM_DEPTH faults. The compare is unsigned over the full ADDR_W.

## Structure
- Shared package cpu_mem_pkg:
  - State enum (IDLE, ISSUE, WAIT, RESP)
  - ADDR_W/DATA_W/MEM_DEPTH defaults
  - Request/response field widths
- Single module, no sub-module. The latency counter is 3 bits, inline.

## Test plan
- Store 0x00AA to addr 3, then load addr 3 -> Memwrite high exactly in T+1. Load resp_data=0x00AA, resp_fault=0, resp_valid at T+3.
- Load addr 0 with RD_LATENCY=3 after preloading 20 -> resp_valid at T+5, resp_data=20, Memread high for exactly one cycle.
- Load addr 16 (MEM_DEPTH=16) -> resp_fault=1, resp_data=0 at T+1, Memread/Memwrite never high. Addr 15 succeeds.
- Hold resp_ready low 5 cycles in RESP -> resp_valid/resp_data/resp_rd stable and req_ready low. Release -> IDLE, next request accepted the following cycle.
- Assert Rst_n low during WAIT -> outputs at reset values immediately, no response ever issued for that tag, next request works normally.
- Back-to-back 8 random loads/stores with random resp_ready -> every tag returned once, in order, data matching a reference model.
